circle: RTL and testbench
=========================

// Module: circle
//
// PURPOSE
// - Bresenham circle rasteriser driving the VGA adapter pixel port. Optionally
//   clears the 160x120 frame to black first.
// - Sits between the lab top level and vga_adapter.
// - Its vga_x/vga_y/vga_plot stream is what the circle agent scoreboards.
//
// PARAMETERS
// SCREEN_W  160  visible columns; plots with x >= SCREEN_W are suppressed
// SCREEN_H  120  visible rows; plots with y >= SCREEN_H are suppressed
//
// PORTS
// clk         in   1  system clock; all state changes on the rising edge
// rst_n       in   1  asynchronous, active-low reset
// colour      in   3  circle colour, latched on start
// centre_x    in   8  centre column, latched on start
// centre_y    in   7  centre row, latched on start
// radius      in   8  radius in pixels (0..255), latched on start
// start       in   1  level request; held high until done is seen
// done        out  1  high in DONE state
// vga_x       out  8  pixel column (registered)
// vga_y       out  7  pixel row (registered)
// vga_colour  out  3  pixel colour (registered)
// vga_plot    out  1  write strobe; pixel is written on the edge where it is high
//
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; done, vga_plot, vga_x, vga_y and
//   vga_colour all 0. Reset mid-draw aborts with no further plots.
// - States: IDLE -> CIRCLE_BLACK -> INIT -> DRAW -> DONE -> IDLE.
// - IDLE: on start=1, latch all inputs. Inputs changing later are ignored.
// - CIRCLE_BLACK: raster with x outer 0..W-1 and y inner 0..H-1.
//   - One pixel per cycle, vga_colour=0, vga_plot=1.
//   - 19200 cycles at the defaults; after the last pixel (159,119) go to INIT.
// - INIT, one cycle, vga_plot=0:
//   - ox=radius, oy=0, crit=1-radius.
//   - Arithmetic is 11-bit signed; coordinates are 10-bit signed.
// - DRAW: while oy <= ox, emit 8 octant pixels, one per cycle, in this order:
//   - (cx+ox,cy+oy) (cx+oy,cy+ox) (cx-ox,cy+oy) (cx-oy,cy+ox)
//   - (cx-ox,cy-oy) (cx-oy,cy-ox) (cx+ox,cy-oy) (cx+oy,cy-ox)
// - DRAW update after the 8th pixel:
//   - oy += 1
//   - if crit <= 0: crit += 2*oy+1
//   - else: ox -= 1, then crit += 2*(oy-ox)+1
// - Loop test uses the updated values. On exit go to DONE.
// - Clipping: vga_x/vga_y always carry the low bits of the computed
//   coordinate. vga_plot=1 only if 0 <= x < W and 0 <= y < H.
//   No wrap-around writes.
// - Duplicate pixels (octant overlaps, radius 0) are emitted, not filtered.
//   Radius 0 gives 8 plots of (cx,cy).
// - DONE: done=1 and vga_plot=0.
//   - Hold while start=1.
//   - On start=0, go to IDLE and drop done next cycle.
//   - A new start is accepted only from IDLE.
// - Latency:
//   - start seen -> first pixel: 1 cycle.
//   - Draw length: 8 cycles per iteration.
//   - Last pixel -> done: 1 cycle.
//
// CONFIGURATION
// - CIRCLE_CLEAR_EN defined: CIRCLE_BLACK is entered as above.
// - CIRCLE_CLEAR_EN undefined: IDLE goes straight to INIT. There is no black
//   pass, and the first pixel is 2 cycles after start.
//
// TESTING
// - Reset low mid-DRAW -> next edge: done=0, vga_plot=0; no plots until a
//   new start.
// - CIRCLE_CLEAR_EN, centre (80,60), r=40, colour 3'b010:
//   - exactly 19200 black plots covering every pixel once.
//   - then the DRAW stream matches the reference model bit-exactly; first
//     pixel (120,60).
//   - done high while start held.
// - Centre (0,0), r=10:
//   - only the x>=0, y>=0 quadrant pixels have vga_plot=1.
//   - (-10,0) etc. have vga_plot=0; no writes at x>=246.
// - r=0 at (5,5) -> 8 plotted cycles all at (5,5), then done.
// - Done handshake: hold start 20 cycles after done -> done stays 1.
//   - Drop start -> done=0 next cycle.
//   - Re-raise start -> new draw with the new inputs.
// - Change centre_x/radius mid-draw -> stream unchanged from the inputs
//   latched at start.

Source files
------------

// File: rtl/circle_if.sv
// Pixel-port and request bundle between the lab top level and the circle rasteriser.
interface circle_if;
    logic [2:0] colour;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic       start;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    modport master (
        output colour, centre_x, centre_y, radius, start,
        input  done, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  colour, centre_x, centre_y, radius, start,
        output done, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/circle.sv
// Bresenham circle rasteriser on the VGA pixel port, 8 octant pixels per step.
// Define CIRCLE_CLEAR_EN to blank the whole frame before each circle.
module circle #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input logic   clk,
    input logic   rst_n,
    circle_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE, CIRCLE_BLACK, INIT, DRAW, DONE
    } state_t;

    localparam logic signed [9:0] LW = 10'(SCREEN_W);
    localparam logic signed [9:0] LH = 10'(SCREEN_H);

    state_t r_state, w_next;

    logic [2:0]         r_col;
    logic [7:0]         r_cx;
    logic [6:0]         r_cy;
    logic [7:0]         r_rad;
    logic signed [10:0] r_ox, r_oy, r_crit;
    logic [2:0]         r_oct;

    logic [7:0] r_vx;
    logic [6:0] r_vy;
    logic [2:0] r_vcol;
    logic       r_vplot, r_done;

    logic signed [9:0]  w_ox10, w_oy10, w_dx, w_dy, w_px, w_py;
    logic signed [10:0] w_oy1, w_ox1, w_crit1;
    logic               w_last, w_plot;
    logic [7:0]         w_x;
    logic [6:0]         w_y;
    logic [2:0]         w_colour;

`ifdef CIRCLE_CLEAR_EN
    localparam logic [7:0] BX_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] BY_LAST = 7'(SCREEN_H - 1);
    logic [7:0] r_bx;
    logic [6:0] r_by;
    logic       w_blast;
    assign w_blast = (r_bx == BX_LAST) && (r_by == BY_LAST);
`endif

    assign w_ox10 = r_ox[9:0];
    assign w_oy10 = r_oy[9:0];

    always_comb begin
        w_dx = w_ox10;
        w_dy = w_oy10;
        case (r_oct)
            3'd0: begin w_dx =  w_ox10; w_dy =  w_oy10; end
            3'd1: begin w_dx =  w_oy10; w_dy =  w_ox10; end
            3'd2: begin w_dx = -w_ox10; w_dy =  w_oy10; end
            3'd3: begin w_dx = -w_oy10; w_dy =  w_ox10; end
            3'd4: begin w_dx = -w_ox10; w_dy = -w_oy10; end
            3'd5: begin w_dx = -w_oy10; w_dy = -w_ox10; end
            3'd6: begin w_dx =  w_ox10; w_dy = -w_oy10; end
            default: begin w_dx = w_oy10; w_dy = -w_ox10; end
        endcase
    end

    assign w_px = $signed({2'b00, r_cx}) + w_dx;
    assign w_py = $signed({3'b000, r_cy}) + w_dy;

    // Step update; the loop test must see the post-update ox/oy
    always_comb begin
        w_oy1   = r_oy + 11'sd1;
        w_ox1   = r_ox;
        w_crit1 = r_crit + (w_oy1 <<< 1) + 11'sd1;
        if (r_crit > 11'sd0) begin
            w_ox1   = r_ox - 11'sd1;
            w_crit1 = r_crit + ((w_oy1 - w_ox1) <<< 1) + 11'sd1;
        end
    end

    assign w_last = (r_oct == 3'd7) && (w_oy1 > w_ox1);

    always_comb begin
        w_next   = r_state;
        w_x      = '0;
        w_y      = '0;
        w_colour = '0;
        w_plot   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
`ifdef CIRCLE_CLEAR_EN
                    w_next = CIRCLE_BLACK;
`else
                    w_next = INIT;
`endif
                end
            end
            CIRCLE_BLACK: begin
`ifdef CIRCLE_CLEAR_EN
                w_x    = r_bx;
                w_y    = r_by;
                w_plot = 1'b1;
                if (w_blast) w_next = INIT;
`else
                w_next = IDLE;
`endif
            end
            INIT: w_next = DRAW;
            DRAW: begin
                w_x      = w_px[7:0];
                w_y      = w_py[6:0];
                w_colour = r_col;
                w_plot   = (w_px >= 10'sd0) && (w_px < LW) &&
                           (w_py >= 10'sd0) && (w_py < LH);
                if (w_last) w_next = DONE;
            end
            DONE: begin
                if (!bus.start) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_vx    <= '0;
            r_vy    <= '0;
            r_vcol  <= '0;
            r_vplot <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vx    <= w_x;
            r_vy    <= w_y;
            r_vcol  <= w_colour;
            r_vplot <= w_plot;
            r_done  <= (r_state == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col  <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
            r_rad  <= '0;
            r_ox   <= '0;
            r_oy   <= '0;
            r_crit <= '0;
            r_oct  <= '0;
`ifdef CIRCLE_CLEAR_EN
            r_bx   <= '0;
            r_by   <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_col <= bus.colour;
                        r_cx  <= bus.centre_x;
                        r_cy  <= bus.centre_y;
                        r_rad <= bus.radius;
`ifdef CIRCLE_CLEAR_EN
                        r_bx  <= '0;
                        r_by  <= '0;
`endif
                    end
                end
`ifdef CIRCLE_CLEAR_EN
                CIRCLE_BLACK: begin
                    if (r_by == BY_LAST) begin
                        r_by <= '0;
                        r_bx <= r_bx + 8'd1;
                    end else begin
                        r_by <= r_by + 7'd1;
                    end
                end
`endif
                INIT: begin
                    r_ox   <= {3'b000, r_rad};
                    r_oy   <= '0;
                    r_crit <= 11'sd1 - $signed({3'b000, r_rad});
                    r_oct  <= '0;
                end
                DRAW: begin
                    r_oct <= r_oct + 3'd1;
                    if (r_oct == 3'd7) begin
                        r_ox   <= w_ox1;
                        r_oy   <= w_oy1;
                        r_crit <= w_crit1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.vga_x      = r_vx;
    assign bus.vga_y      = r_vy;
    assign bus.vga_colour = r_vcol;
    assign bus.vga_plot   = r_vplot;
    assign bus.done       = r_done;

endmodule

// File: tb/tb_circle.sv
// Scoreboard bench for the circle rasteriser: expected pixels are queued
// from a Bresenham model and popped against the DUT stream cycle by cycle.
module tb_circle;

    logic clk;
    logic rst_n;

    circle_if u_if ();

    circle u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if.slave)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic       plot;
        logic [2:0] col;
    } pix_t;

    pix_t q[$];
    int   total;
    int   bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model(input int cx, input int cy, input int r,
                         input logic [2:0] col);
        int   ox, oy, crit, px, py;
        int   dx[8];
        int   dy[8];
        pix_t p;
        ox = r;
        oy = 0;
        crit = 1 - r;
        while (oy <= ox) begin
            dx = '{ox, oy, -ox, -oy, -ox, -oy, ox, oy};
            dy = '{oy, ox, oy, ox, -oy, -ox, -oy, -ox};
            for (int k = 0; k < 8; k++) begin
                px = cx + dx[k];
                py = cy + dy[k];
                p.x = px[7:0];
                p.y = py[6:0];
                p.plot = (px >= 0 && px < 160 && py >= 0 && py < 120);
                p.col = col;
                q.push_back(p);
            end
            oy++;
            if (crit <= 0) begin
                crit += 2 * oy + 1;
            end else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end
    endtask

    task automatic run_circle(input int cx, input int cy, input int r,
                              input logic [2:0] col, input bit perturb,
                              output int nplot, output int nexp,
                              output int fx, output int fy);
        pix_t e;
        int   idx;
        nplot = 0;
        nexp = 0;
        idx = 0;
        fx = -1;
        fy = -1;
        q.delete();
        model(cx, cy, r, col);
        foreach (q[i]) if (q[i].plot) nexp++;
        u_if.centre_x = 8'(cx);
        u_if.centre_y = 7'(cy);
        u_if.radius = 8'(r);
        u_if.colour = col;
        u_if.start = 1'b1;
        tick;
        if (perturb) begin
            u_if.centre_x = ~u_if.centre_x;
            u_if.centre_y = ~u_if.centre_y;
            u_if.radius = u_if.radius + 8'd3;
            u_if.colour = ~u_if.colour;
        end
`ifdef CIRCLE_CLEAR_EN
        for (int xx = 0; xx < 160; xx++) begin
            for (int yy = 0; yy < 120; yy++) begin
                tick;
                total++;
                if (u_if.vga_x !== 8'(xx) || u_if.vga_y !== 7'(yy) ||
                    u_if.vga_plot !== 1'b1 || u_if.vga_colour !== 3'd0 ||
                    u_if.done !== 1'b0) begin
                    bad++;
                    $display("FAIL black: got x=%0d y=%0d plot=%0b col=%0d, want x=%0d y=%0d plot=1 col=0",
                             u_if.vga_x, u_if.vga_y, u_if.vga_plot,
                             u_if.vga_colour, xx, yy);
                end
            end
        end
`endif
        tick;
        total++;
        if (u_if.vga_plot !== 1'b0 || u_if.done !== 1'b0) begin
            bad++;
            $display("FAIL init_gap: got plot=%0b done=%0b, want 0 0",
                     u_if.vga_plot, u_if.done);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            tick;
            if (idx == 0) begin
                fx = int'(u_if.vga_x);
                fy = int'(u_if.vga_y);
            end
            if (u_if.vga_plot === 1'b1) nplot++;
            total++;
            if (u_if.vga_x !== e.x || u_if.vga_y !== e.y ||
                u_if.vga_plot !== e.plot || u_if.done !== 1'b0 ||
                (e.plot && u_if.vga_colour !== e.col)) begin
                bad++;
                $display("FAIL pixel%0d: got x=%0d y=%0d plot=%0b col=%0d done=%0b, want x=%0d y=%0d plot=%0b col=%0d",
                         idx, u_if.vga_x, u_if.vga_y, u_if.vga_plot,
                         u_if.vga_colour, u_if.done, e.x, e.y, e.plot, e.col);
            end
            idx++;
        end
        tick;
        total++;
        if (u_if.done !== 1'b1 || u_if.vga_plot !== 1'b0) begin
            bad++;
            $display("FAIL done_rise: got done=%0b plot=%0b, want 1 0",
                     u_if.done, u_if.vga_plot);
        end
    endtask

    task automatic release_start;
        u_if.start = 1'b0;
        tick;
        tick;
        total++;
        if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0) begin
            bad++;
            $display("FAIL done_drop: got done=%0b plot=%0b, want 0 0",
                     u_if.done, u_if.vga_plot);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        u_if.start = 1'b0;
        u_if.colour = '0;
        u_if.centre_x = '0;
        u_if.centre_y = '0;
        u_if.radius = '0;
        repeat (3) tick;
        total++;
        if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0 ||
            u_if.vga_x !== 8'd0 || u_if.vga_y !== 7'd0 ||
            u_if.vga_colour !== 3'd0) begin
            bad++;
            $display("FAIL reset: got done=%0b plot=%0b x=%0d y=%0d col=%0d, want all 0",
                     u_if.done, u_if.vga_plot, u_if.vga_x, u_if.vga_y,
                     u_if.vga_colour);
        end
        rst_n = 1'b1;
        repeat (2) tick;
        total++;
        if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0) begin
            bad++;
            $display("FAIL idle: got done=%0b plot=%0b, want 0 0",
                     u_if.done, u_if.vga_plot);
        end
    endtask

    task automatic test_basic;
        int np, ne, fx, fy;
        run_circle(80, 60, 40, 3'b010, 1'b0, np, ne, fx, fy);
        total++;
        if (fx !== 120 || fy !== 60) begin
            bad++;
            $display("FAIL first_pixel: got (%0d,%0d), want (120,60)", fx, fy);
        end
    endtask

    task automatic test_back_to_back;
        int np, ne, fx, fy;
        for (int i = 0; i < 20; i++) begin
            tick;
            total++;
            if (u_if.done !== 1'b1 || u_if.vga_plot !== 1'b0) begin
                bad++;
                $display("FAIL done_hold%0d: got done=%0b plot=%0b, want 1 0",
                         i, u_if.done, u_if.vga_plot);
            end
        end
        release_start();
        run_circle(30, 20, 7, 3'b110, 1'b0, np, ne, fx, fy);
        total++;
        if (fx !== 37 || fy !== 20) begin
            bad++;
            $display("FAIL b2b_first: got (%0d,%0d), want (37,20)", fx, fy);
        end
        release_start();
    endtask

    task automatic test_clip;
        int np, ne, fx, fy;
        run_circle(0, 0, 10, 3'b001, 1'b0, np, ne, fx, fy);
        total++;
        if (np !== ne) begin
            bad++;
            $display("FAIL clip_count: got %0d plots, want %0d", np, ne);
        end
        release_start();
    endtask

    task automatic test_r0;
        int np, ne, fx, fy;
        run_circle(5, 5, 0, 3'b111, 1'b0, np, ne, fx, fy);
        total++;
        if (np !== 8) begin
            bad++;
            $display("FAIL r0_count: got %0d plots, want 8", np);
        end
        release_start();
    endtask

    task automatic test_latch;
        int np, ne, fx, fy;
        run_circle(40, 50, 15, 3'b101, 1'b1, np, ne, fx, fy);
        release_start();
    endtask

    task automatic test_reset_mid;
        u_if.centre_x = 8'd80;
        u_if.centre_y = 7'd60;
        u_if.radius = 8'd50;
        u_if.colour = 3'b011;
        u_if.start = 1'b1;
        tick;
`ifdef CIRCLE_CLEAR_EN
        repeat (100) tick;
`else
        repeat (22) tick;
`endif
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: got done=%0b plot=%0b, want 0 0",
                     u_if.done, u_if.vga_plot);
        end
        tick;
        total++;
        if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0) begin
            bad++;
            $display("FAIL rst_edge: got done=%0b plot=%0b, want 0 0",
                     u_if.done, u_if.vga_plot);
        end
        u_if.start = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick;
            total++;
            if (u_if.done !== 1'b0 || u_if.vga_plot !== 1'b0) begin
                bad++;
                $display("FAIL rst_quiet%0d: got done=%0b plot=%0b, want 0 0",
                         i, u_if.done, u_if.vga_plot);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_back_to_back();
`ifndef CIRCLE_CLEAR_EN
        test_clip();
        test_latch();
`endif
        test_reset_mid();
        test_r0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
